// File: rtl/cam_pkg.sv
// cam_pkg: CAM op codes, sequencer FSM states and the decoded result record
package cam_pkg;
  localparam int CAM_IDLE        = 0;
  localparam int CAM_UPDATE_ALL  = 1;
  localparam int CAM_SEARCH      = 2;
  localparam int CAM_UPDATE_ONE  = 3;
  localparam int MAX_INDEX_WIDTH = 16;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_END, S_SEARCH, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic                       hit;
    logic [MAX_INDEX_WIDTH-1:0] index;
  } cam_result_t;
endpackage

// File: rtl/cam_result_fifo.sv
// cam_result_fifo: synchronous FIFO for decoded CAM results
// clk/rst: clock and sync active-high reset; push/wdata: write side; pop/rdata: show-ahead read side
// count/full/empty: occupancy status
module cam_result_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push);
      rptr  <= rptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign rdata = mem[rptr];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // credit gating upstream guarantees a push into a full FIFO always pairs with a pop
  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/cam_host_sequencer.sv
// cam_host_sequencer: loads the CAM table, issues credit-gated search keys and returns decoded results
// ctrl_*: run control/status; ld_*: table-beat stream in; key_*: search-key stream in
// cam_*: registered op code/data to the CAM core plus its result/load-end inputs; res_*: result stream out
module cam_host_sequencer
  import cam_pkg::*;
#(
  parameter int CAM_SIZE       = 256,
  parameter int INDEX_WIDTH    = $clog2(CAM_SIZE),
  parameter int C_DATA_WIDTH   = 512,
  parameter int KEY_WIDTH      = 48,
  parameter int RES_FIFO_DEPTH = 16,
  parameter int OP_CODE_WIDTH  = 3
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     ctrl_start,
  input  logic                     ctrl_skip_load,
  input  logic [31:0]              ctrl_num_keys,
  output logic                     ctrl_busy,
  output logic                     ctrl_done,
  input  logic                     ld_tvalid,
  output logic                     ld_tready,
  input  logic [C_DATA_WIDTH-1:0]  ld_tdata,
  input  logic                     key_tvalid,
  output logic                     key_tready,
  input  logic [KEY_WIDTH-1:0]     key_tdata,
  output logic [OP_CODE_WIDTH-1:0] cam_state,
  output logic                     cam_tvalid,
  output logic [C_DATA_WIDTH-1:0]  cam_tdata,
  input  logic                     cam_update_all_end,
  input  logic                     cam_m_tvalid,
  input  logic [C_DATA_WIDTH-1:0]  cam_m_tdata,
  output logic                     res_tvalid,
  input  logic                     res_tready,
  output logic                     res_hit,
  output logic [INDEX_WIDTH-1:0]   res_index
);
  localparam int BEATS = CAM_SIZE / 8;
  localparam int BW    = $clog2(BEATS) + 1;
  localparam int CW    = $clog2(RES_FIFO_DEPTH) + 1;
  state_t state, state_nx;
  logic [BW-1:0] beats;
  logic [31:0] num_keys, keys_issued;
  logic [CW-1:0] outstanding, fifo_count;
  logic [CW:0] used;
  logic [OP_CODE_WIDTH-1:0] op_nx;
  logic fifo_full, fifo_empty, ld_acc, key_acc, ret, pop, hit, unused;
  cam_result_t res_in, res_out;
  assign ld_acc  = ld_tvalid && ld_tready;
  assign key_acc = key_tvalid && key_tready;
  // results are only accepted while something is in flight, so stale CAM output after a reset is dropped
  assign ret  = cam_m_tvalid && outstanding != '0;
  assign used = {1'b0, outstanding} + {1'b0, fifo_count};
  always_ff @(posedge aclk) state <= areset ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (ctrl_start) state_nx = ctrl_skip_load ? (ctrl_num_keys == '0 ? S_DONE : S_SEARCH) : S_LOAD;
      S_LOAD:     if (ld_acc && beats == BW'(BEATS - 1)) state_nx = S_WAIT_END;
      S_WAIT_END: if (cam_update_all_end) state_nx = num_keys == '0 ? S_DONE : S_SEARCH;
      S_SEARCH:   if (keys_issued == num_keys) state_nx = S_DRAIN;
      S_DRAIN:    if (outstanding == '0 && fifo_empty) state_nx = S_DONE;
      default:    state_nx = S_IDLE;
    endcase
  end
  // DRAIN keeps the SEARCH op code because the CAM result pipeline only advances in SEARCH
  always_comb begin
    ld_tready  = state == S_LOAD;
    key_tready = state == S_SEARCH && keys_issued < num_keys && used < (CW+1)'(RES_FIFO_DEPTH);
    ctrl_busy  = state != S_IDLE;
    op_nx      = state_nx inside {S_LOAD, S_WAIT_END} ? OP_CODE_WIDTH'(CAM_UPDATE_ALL) :
                 state_nx inside {S_SEARCH, S_DRAIN}  ? OP_CODE_WIDTH'(CAM_SEARCH) : OP_CODE_WIDTH'(CAM_IDLE);
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      beats       <= '0;
      num_keys    <= '0;
      keys_issued <= '0;
      outstanding <= '0;
      cam_state   <= OP_CODE_WIDTH'(CAM_IDLE);
      cam_tvalid  <= 1'b0;
      cam_tdata   <= '0;
      ctrl_done   <= 1'b0;
    end else begin
      beats       <= state == S_IDLE ? '0 : beats + BW'(ld_acc);
      num_keys    <= state == S_IDLE && ctrl_start ? ctrl_num_keys : num_keys;
      keys_issued <= state == S_IDLE ? '0 : keys_issued + 32'(key_acc);
      outstanding <= outstanding + CW'(key_acc) - CW'(ret);
      cam_state   <= op_nx;
      cam_tvalid  <= ld_acc || key_acc;
      cam_tdata   <= ld_acc ? ld_tdata : key_acc ? C_DATA_WIDTH'(key_tdata) : cam_tdata;
      ctrl_done   <= state == S_DONE;
    end
  end
  assign hit    = cam_m_tdata[INDEX_WIDTH:0] != '1;
  assign res_in = '{hit: hit, index: hit ? MAX_INDEX_WIDTH'(cam_m_tdata[INDEX_WIDTH-1:0]) : '0};
  assign pop    = res_tvalid && res_tready;
  cam_result_fifo #(.DEPTH(RES_FIFO_DEPTH), .WIDTH($bits(cam_result_t))) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (ret),
    .wdata (res_in),
    .pop   (pop),
    .rdata (res_out),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
  assign res_tvalid = !fifo_empty;
  assign res_hit    = !fifo_empty && res_out.hit;
  assign res_index  = fifo_empty ? '0 : res_out.index[INDEX_WIDTH-1:0];
  assign unused = ^{cam_m_tdata[C_DATA_WIDTH-1:INDEX_WIDTH+1], res_out.index[MAX_INDEX_WIDTH-1:INDEX_WIDTH],
                    fifo_full, 32'(CAM_UPDATE_ONE)};
endmodule

// File: tb/tb_cam_host_sequencer.sv
// tb_cam_host_sequencer: scoreboard bench with a 4-cycle CAM model behind the sequencer
module tb_cam_host_sequencer;
  logic aclk = 0, areset = 1;
  logic ctrl_start = 0, ctrl_skip_load = 0;
  logic [31:0] ctrl_num_keys = 0;
  logic ctrl_busy, ctrl_done, ld_tready, key_tready, cam_tvalid, cam_m_tvalid, res_tvalid, res_hit;
  logic ld_tvalid = 0, key_tvalid = 0, cam_update_all_end = 0, res_tready = 0;
  logic [511:0] ld_tdata = '0;
  logic [47:0] key_tdata = '0;
  logic [2:0] cam_state;
  logic [511:0] cam_tdata, cam_m_tdata;
  logic [7:0] res_index;
  int errors = 0, checks = 0, n_issued = 0, n_res = 0, n_done = 0, n_camv = 0;
  int base_res, base_iss, base_camv;
  logic [8:0] exp_q[$];

  cam_host_sequencer dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_skip_load(ctrl_skip_load),
    .ctrl_num_keys(ctrl_num_keys), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .ld_tvalid(ld_tvalid), .ld_tready(ld_tready), .ld_tdata(ld_tdata),
    .key_tvalid(key_tvalid), .key_tready(key_tready), .key_tdata(key_tdata),
    .cam_state(cam_state), .cam_tvalid(cam_tvalid), .cam_tdata(cam_tdata),
    .cam_update_all_end(cam_update_all_end), .cam_m_tvalid(cam_m_tvalid), .cam_m_tdata(cam_m_tdata),
    .res_tvalid(res_tvalid), .res_tready(res_tready), .res_hit(res_hit), .res_index(res_index)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CAM model: table filled from UPDATE_ALL beats, 4-stage lookup pipeline that advances only in SEARCH
  logic [47:0] tbl [256];
  int ld_beat = 0;
  logic [3:0] pv = '0;
  logic [8:0] pd [4];
  function automatic logic [8:0] lookup(input logic [47:0] k, input int n);
    for (int i = 0; i < n && i < 256; i++) if (tbl[i] == k) return 9'(i);
    return 9'h1FF;
  endfunction
  always @(posedge aclk) begin
    if (areset) pv <= '0;
    else if (cam_state == 3'd2) begin
      pv <= {pv[2:0], cam_tvalid};
      pd[0] <= lookup(cam_tdata[47:0], ld_beat * 8);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
    if (!areset && cam_state == 3'd1 && cam_tvalid) begin
      for (int k = 0; k < 8; k++) tbl[(ld_beat % 32) * 8 + k] <= cam_tdata[k*64 +: 48];
      ld_beat <= ld_beat + 1;
    end
  end
  assign cam_m_tvalid = pv[3] && cam_state == 3'd2;
  assign cam_m_tdata  = {8'hC3, 495'd0, pd[3]};

  function automatic logic [8:0] exp_of(input logic [47:0] k);
    return (k >= 48'h100 && k <= 48'h1FF) ? {1'b1, k[7:0]} : 9'h0;
  endfunction

  // result monitor: pops the scoreboard on each handshake and checks stall stability
  logic stall = 0;
  logic [8:0] held = '0;
  always @(negedge aclk) begin
    if (areset) stall = 0;
    else begin
      if (stall) check("res_hold", {res_tvalid, res_hit, res_index}, {1'b1, held});
      if (res_tvalid && res_tready) begin
        n_res++;
        if (exp_q.size() == 0) check("res_unexpected", 64'(exp_q.size()), 64'd1);
        else check("res", {res_hit, res_index}, exp_q.pop_front());
      end
      stall = res_tvalid && !res_tready;
      held = {res_hit, res_index};
      if (ctrl_done) n_done++;
      if (cam_tvalid) n_camv++;
    end
  end

  task automatic start(input logic skip, input int n);
    ctrl_skip_load = skip;
    ctrl_num_keys = n;
    ctrl_start = 1;
    @(posedge aclk); #1 ctrl_start = 0;
  endtask

  task automatic send_key(input logic [47:0] k);
    int t = 0;
    key_tdata = k;
    key_tvalid = 1;
    @(negedge aclk);
    while (!key_tready && t < 3000) begin @(negedge aclk); t++; end
    if (!key_tready) check("key_timeout", key_tready, 1);
    else begin
      exp_q.push_back(exp_of(k));
      n_issued++;
    end
    @(posedge aclk); #1 key_tvalid = 0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    int base = n_done;
    while (n_done == base && t < 5000) begin @(posedge aclk); t++; end
    check(tag, n_done - base, 1);
    repeat (3) @(posedge aclk);
    #1;
    check({tag, "_once"}, n_done - base, 1);
    check({tag, "_idle"}, ctrl_busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check("rst_busy", ctrl_busy, 0);
    check("rst_outs", {ctrl_done, ld_tready, key_tready, cam_tvalid, res_tvalid, res_hit, res_index, cam_state}, 0);
    check("rst_tdata", 64'(|cam_tdata), 0);
    areset = 0;
    // table load with one gap cycle
    start(0, 4);
    check("load_state", cam_state, 1);
    for (int b = 0; b < 32; b++) begin
      if (b == 10) begin
        ld_tvalid = 0;
        @(posedge aclk); #1;
        check("gap_tvalid", cam_tvalid, 0);
      end
      for (int k = 0; k < 8; k++) ld_tdata[k*64 +: 64] = {16'hA5A5, 48'h100 + 48'(b * 8 + k)};
      ld_tvalid = 1;
      @(negedge aclk);
      check("ld_ready", ld_tready, 1);
      @(posedge aclk); #1;
      if (b == 0) begin
        check("ld_cam_tvalid", cam_tvalid, 1);
        check("ld_cam_tdata", 64'(cam_tdata == ld_tdata), 1);
      end
    end
    ld_tvalid = 0;
    check("ld_ready_end", ld_tready, 0);
    repeat (3) @(posedge aclk);
    #1;
    check("wait_state", cam_state, 1);
    check("wait_tvalid", cam_tvalid, 0);
    check("wait_busy", ctrl_busy, 1);
    cam_update_all_end = 1;
    @(posedge aclk); #1 cam_update_all_end = 0;
    check("search_state", cam_state, 2);
    // hits at both ends of the table and a miss
    res_tready = 1;
    base_res = n_res;
    send_key(48'h105);
    send_key(48'h1FF);
    send_key(48'h100);
    send_key(48'hDEAD);
    wait_done("run1_done");
    check("run1_results", n_res - base_res, 4);
    check("run1_queue", exp_q.size(), 0);
    // credit limit with results backed up
    start(1, 40);
    res_tready = 0;
    base_iss = n_issued;
    base_res = n_res;
    fork
      for (int i = 0; i < 40; i++)
        send_key(i % 5 == 4 ? 48'hBAD000 + 48'(i) : 48'h100 + 48'((i * 37) % 256));
    join_none
    repeat (150) @(posedge aclk);
    #1;
    check("credit_issued", n_issued - base_iss, 16);
    check("credit_ready", key_tready, 0);
    check("credit_held", n_res - base_res, 0);
    res_tready = 1;
    wait_done("run2_done");
    check("run2_results", n_res - base_res, 40);
    check("run2_queue", exp_q.size(), 0);
    // reset with three searches in flight
    start(1, 5);
    send_key(48'h1AB);
    send_key(48'h1C0);
    send_key(48'h1FE);
    areset = 1;
    @(posedge aclk); #1;
    check("mid_rst_busy", ctrl_busy, 0);
    check("mid_rst_outs", {ctrl_done, ld_tready, key_tready, cam_tvalid, res_tvalid, res_hit, res_index, cam_state}, 0);
    check("mid_rst_tdata", 64'(|cam_tdata), 0);
    exp_q.delete();
    areset = 0;
    base_res = n_res;
    start(1, 2);
    send_key(48'h1AB);
    send_key(48'h123);
    wait_done("run3_done");
    check("run3_results", n_res - base_res, 2);
    check("run3_queue", exp_q.size(), 0);
    // zero keys without load
    base_camv = n_camv;
    start(1, 0);
    check("zero_done_early", ctrl_done, 0);
    @(posedge aclk); #1;
    check("zero_done", ctrl_done, 1);
    @(posedge aclk); #1;
    check("zero_done_end", ctrl_done, 0);
    check("zero_idle", ctrl_busy, 0);
    check("zero_camv", n_camv - base_camv, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cam_host_sequencer.md
Name: cam_host_sequencer

Overview:
- Drives the CAM core from the host side: issues the table load, then the search keys, and collects the match results.
- Loads all CAM_SIZE entries as CAM_SIZE/8 beats of 512 bits in UPDATE_ALL, then streams 48-bit keys in SEARCH.
- The CAM core has no backpressure, so the block gates key issue with credits against an internal result FIFO, then returns decoded hit/index results on a ready/valid stream.
- Sits between the HBM-fed AXI4-Stream adapters and the CAM core.

Parameters:
- CAM_SIZE, 256, number of CAM entries; multiple of 8.
- INDEX_WIDTH, $clog2(CAM_SIZE), match index width.
- C_DATA_WIDTH, 512, CAM data bus width.
- KEY_WIDTH, 48, search key width.
- RES_FIFO_DEPTH, 16, result FIFO entries; power of 2, at least 8.
- OP_CODE_WIDTH, 3, CAM state code width.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- ctrl_start  in  1  one-cycle start pulse; ignored unless the FSM is in IDLE
- ctrl_skip_load  in  1  sampled with ctrl_start; 1 = go straight to SEARCH
- ctrl_num_keys  in  32  keys to search; sampled with ctrl_start
- ctrl_busy  out  1  high whenever the FSM is not in IDLE
- ctrl_done  out  1  one-cycle pulse when a run completes
- ld_tvalid  in  1  entry-beat valid; lane k is bits [k*64+:48]
- ld_tready  out  1  entry-beat ready
- ld_tdata  in  512  entry beat
- key_tvalid  in  1  key valid
- key_tready  out  1  key ready
- key_tdata  in  48  search key
- cam_state  out  OP_CODE_WIDTH  CAM op code: 0 IDLE, 1 UPDATE_ALL, 2 SEARCH
- cam_tvalid  out  1  CAM input valid
- cam_tdata  out  512  CAM input data
- cam_update_all_end  in  1  CAM load-complete pulse
- cam_m_tvalid  in  1  CAM result valid
- cam_m_tdata  in  512  CAM result; bits [INDEX_WIDTH:0] hold the index, all-ones = no match
- res_tvalid  out  1  result valid
- res_tready  in  1  result ready
- res_hit  out  1  1 = match found
- res_index  out  INDEX_WIDTH  match index; 0 when res_hit = 0

Behaviour:
- Reset values: ctrl_busy, ctrl_done, ld_tready, key_tready, cam_tvalid, res_tvalid, res_hit and res_index are all 0. cam_state = IDLE. cam_tdata = 0. FIFO is empty. Counters and credits are cleared.
- Reset mid-run: return to IDLE on the next edge. Any in-flight results are discarded.
- All outputs to the CAM are registered.
- FSM states: IDLE, LOAD, WAIT_END, SEARCH, DRAIN, DONE.
- IDLE: on ctrl_start, go to SEARCH if ctrl_skip_load = 1, otherwise go to LOAD. Latch ctrl_num_keys.
- ctrl_num_keys = 0 with skip_load: go IDLE -> DONE (skip SEARCH). With load: go WAIT_END -> DONE.
- LOAD: cam_state = UPDATE_ALL. ld_tready = 1.
  - Each accepted beat produces cam_tvalid = 1 with cam_tdata = ld_tdata on the next cycle.
  - Count accepted beats. After beat CAM_SIZE/8 - 1 is accepted, go to WAIT_END.
  - A gap on ld_tvalid produces cam_tvalid = 0. The CAM write pointer holds.
- WAIT_END: cam_state stays UPDATE_ALL. cam_tvalid = 0. On cam_update_all_end = 1, go to SEARCH, or to DONE if no keys are requested.
  - cam_update_all_end arriving in any other state is ignored.
- SEARCH: cam_state = SEARCH.
  - key_tready = (keys_issued < num_keys) && (outstanding + fifo_count < RES_FIFO_DEPTH).
  - Each accepted key produces cam_tvalid = 1 one cycle later, with cam_tdata = zero-extended key in [47:0].
  - Increment outstanding on issue. Decrement it on cam_m_tvalid. Same-cycle issue and return leaves it unchanged.
  - When keys_issued == num_keys, go to DRAIN.
- DRAIN: cam_state stays SEARCH, because the CAM result pipeline only advances in SEARCH. cam_tvalid = 0. When outstanding == 0 and the FIFO is empty, go to DONE.
- DONE: pulse ctrl_done for one cycle, then go to IDLE.
- Result capture: on cam_m_tvalid, push {hit, index} into the FIFO.
  - hit = (cam_m_tdata[INDEX_WIDTH:0] != all-ones).
  - index = cam_m_tdata[INDEX_WIDTH-1:0] when hit, else 0.
  - The FIFO never overflows because of the credit rule. An overflow is an assertion failure.
- Result output: standard valid/ready.
  - res_tvalid stays high with stable data until res_tready is seen.
  - Simultaneous push and pop is allowed when full or empty. Empty push-through has 1-cycle latency to res_tvalid.
- Keys leave the block in order; results return in order; the CAM adds no reordering.

Decomposition:
- Package cam_pkg holds:
  - op-code localparams CAM_IDLE = 0, CAM_UPDATE_ALL = 1, CAM_SEARCH = 2, CAM_UPDATE_ONE = 3;
  - FSM state enum;
  - the result struct {hit, index}.
- Sub-module cam_result_fifo: synchronous FIFO, parameterised depth and width, exporting count, full and empty.

Test Plan:
- Reset, then ctrl_start with skip_load = 0 and 32 back-to-back beats where entry i = 48'h100 + i, then cam_update_all_end -> ld_tready is high for exactly 32 accepted beats, cam_state = 1 during LOAD and WAIT_END, then 2.
- Search keys 48'h105, 48'h1FF, 48'h100, using a CAM model with 4-cycle latency -> results in order: (hit 1, index 5), (hit 1, index 255), (hit 1, index 0); ctrl_done pulses once after the last result pops.
- Key with no match (CAM returns 9'h1FF) -> res_hit = 0, res_index = 0.
- res_tready held low while 40 keys are offered with RES_FIFO_DEPTH = 16 -> at most 16 keys are issued, key_tready drops, no result is lost, and all 40 results drain in order after ready rises.
- Assert areset in the middle of SEARCH with 3 results outstanding -> next cycle is IDLE with all outputs at reset values; a new run then completes cleanly.
- ctrl_skip_load = 1 with ctrl_num_keys = 0 -> ctrl_done pulses 2 cycles after start, and cam_tvalid is never asserted.
